// File: rtl/rv_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control path: state, instruction class and datapath
// select encodings. imm_gen imports imm_sel_e from here as well.
package rv_ctrl_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmU = 3'b011,
    ImmJ = 3'b100
  } imm_sel_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsLui,
    ClsAuipc,
    ClsJal,
    ClsJalr,
    ClsBranch,
    ClsLoad,
    ClsStore,
    ClsOpImm,
    ClsOp
  } iclass_e;

  typedef enum logic [1:0] {SrcARs1 = 2'd0, SrcAPc = 2'd1, SrcAZero = 2'd2} alu_src_a_e;
  typedef enum logic [1:0] {SrcBRs2 = 2'd0, SrcBImm = 2'd1, SrcBFour = 2'd2} alu_src_b_e;
  typedef enum logic [1:0] {AluAdd = 2'd0, AluSub = 2'd1, AluFunct = 2'd2} alu_op_e;
  typedef enum logic [1:0] {PcPlus4 = 2'd0, PcAlu = 2'd1, PcAluAlign = 2'd2} pc_src_e;
  typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc = 2'd2} wb_sel_e;

  // ClsNone marks an opcode this core does not implement.
  function automatic iclass_e classify(input logic [6:0] opc);
    case (opc)
      OpcLui:    return ClsLui;
      OpcAuipc:  return ClsAuipc;
      OpcJal:    return ClsJal;
      OpcJalr:   return ClsJalr;
      OpcBranch: return ClsBranch;
      OpcLoad:   return ClsLoad;
      OpcStore:  return ClsStore;
      OpcOpImm:  return ClsOpImm;
      OpcOp:     return ClsOp;
      default:   return ClsNone;
    endcase
  endfunction

  function automatic imm_sel_e imm_of(input iclass_e cls);
    case (cls)
      ClsStore:           return ImmS;
      ClsBranch:          return ImmB;
      ClsLui, ClsAuipc:   return ImmU;
      ClsJal:             return ImmJ;
      default:            return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts stalled memory-request cycles and flags the cycle on which the wait would reach
// MEM_TIMEOUT; MEM_TIMEOUT = 0 disables the flag.
module mem_timeout_cnt #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on a stalled cycle, so mem_ready on the limit cycle always wins.
  assign expire = (MEM_TIMEOUT != 0) && inc && (cnt_q == Limit - 1'b1);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback, with a
// sticky trap on unknown opcodes, bad branch funct3 or memory timeout.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal_instr
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d;
  logic    br_take_q, br_take_d;
  logic    illegal_q;
  logic    stall, tmo_clr, expire;

  // funct7_5 only matters to the ALU function decoder downstream.
  logic unused_funct7_5;
  assign unused_funct7_5 = funct7_5;

  assign stall   = mem_req & ~mem_ready;
  assign tmo_clr = mem_ready | (state_d != state_q);

  mem_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (tmo_clr),
    .expire(expire)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    br_take_d = br_take_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        class_d   = classify(opcode);
        br_take_d = 1'b0;
        state_d   = (class_d == ClsNone) ? StTrap : StExecute;
      end
      StExecute: begin
        unique case (class_q)
          ClsOp, ClsOpImm, ClsLui, ClsAuipc: state_d = StWriteback;
          ClsLoad, ClsStore:                 state_d = StMemory;
          ClsJal, ClsJalr:                   state_d = StFetch;
          ClsBranch: begin
            if (br_take_q) begin
              br_take_d = 1'b0;
              state_d   = StFetch;
            end else if (funct3[2:1] == 2'b00) begin
              // BEQ takes on zero, BNE on non-zero; a taken branch spends one more
              // EXECUTE cycle computing the target.
              if (alu_zero ^ funct3[0]) begin
                br_take_d = 1'b1;
              end else begin
                state_d = StFetch;
              end
            end else begin
              state_d = StTrap;
            end
          end
          default: state_d = StTrap;
        endcase
      end
      StMemory: begin
        if (mem_ready) begin
          state_d = (class_q == ClsStore) ? StFetch : StWriteback;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StWriteback: state_d = StFetch;
      StTrap:      state_d = StTrap;
      default:     state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      class_q   <= ClsNone;
      br_take_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      br_take_q <= br_take_d;
      illegal_q <= illegal_q | (state_d == StTrap);
    end
  end

  assign illegal_instr = illegal_q;

  // Outputs are forced idle while rst is high so an in-flight request drops immediately.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PcPlus4;
    imm_sel      = ImmI;
    alu_src_a    = SrcARs1;
    alu_src_b    = SrcBRs2;
    alu_op       = AluAdd;
    reg_we       = 1'b0;
    wb_sel       = WbAlu;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        StExecute: begin
          imm_sel = imm_of(class_q);
          unique case (class_q)
            ClsOp: alu_op = AluFunct;
            ClsOpImm: begin
              alu_src_b = SrcBImm;
              alu_op    = AluFunct;
            end
            ClsLoad, ClsStore: alu_src_b = SrcBImm;
            ClsBranch: begin
              if (br_take_q) begin
                alu_src_a = SrcAPc;
                alu_src_b = SrcBImm;
                pc_we     = 1'b1;
                pc_src    = PcAlu;
              end else begin
                alu_op = AluSub;
              end
            end
            ClsJal, ClsJalr: begin
              alu_src_a = (class_q == ClsJal) ? SrcAPc : SrcARs1;
              alu_src_b = SrcBImm;
              pc_we     = 1'b1;
              pc_src    = (class_q == ClsJal) ? PcAlu : PcAluAlign;
              reg_we    = 1'b1;
              wb_sel    = WbPc;
            end
            ClsLui: begin
              alu_src_a = SrcAZero;
              alu_src_b = SrcBImm;
            end
            ClsAuipc: begin
              alu_src_a = SrcAPc;
              alu_src_b = SrcBImm;
            end
            default: ;
          endcase
        end
        StMemory: begin
          // Keep the address computation on the ALU for the whole access.
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (class_q == ClsStore);
          imm_sel      = imm_of(class_q);
          alu_src_b    = SrcBImm;
        end
        StWriteback: begin
          reg_we = 1'b1;
          wb_sel = (class_q == ClsLoad) ? WbMem : WbAlu;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions cycle by cycle and compares the whole
// control vector against hand-written expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, illegal_instr;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] imm_sel;

  int errors = 0;
  int checks = 0;

  logic [19:0] v_fetch, v_fstall, v_trap;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .illegal_instr(illegal_instr)
  );

  // Field order: req we asel ir_we pc_we pc_src imm a b op reg_we wb illegal
  function automatic logic [19:0] ctl(input logic req, input logic we, input logic asel,
                                      input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                      input logic [2:0] imm, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op,
                                      input logic rwe, input logic [1:0] wb, input logic ill);
    return {req, we, asel, irwe, pcwe, pcs, imm, a, b, op, rwe, wb, ill};
  endfunction

  function automatic logic [19:0] obs();
    return {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, imm_sel, alu_src_a,
            alu_src_b, alu_op, reg_we, wb_sel, illegal_instr};
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Inputs for the current cycle are set before calling; outputs are sampled at negedge.
  task automatic step(input string tag, input logic [19:0] exp);
    @(negedge clk);
    check(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] w);
    opcode   = w[6:0];
    funct3   = w[14:12];
    funct7_5 = w[30];
  endtask

  initial begin
    v_fetch  = ctl(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v_fstall = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_trap   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst       = 1'b1;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    set_instr(32'h0);
    repeat (2) @(posedge clk);
    #1;
    step("reset", '0);
    rst = 1'b0;

    // ADDI x1,x0,5: F D E W, reg_we in cycle 4
    set_instr(32'h00500093);
    mem_ready = 1'b1;
    step("addi F", v_fetch);
    step("addi D", '0);
    step("addi E", ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    step("addi W", ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // SW x1,8(x2): memory stalls 3 cycles, request/store held 4 cycles
    set_instr(32'h00112423);
    step("sw F", v_fetch);
    step("sw D", '0);
    step("sw E", ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw M wait", ctl(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    mem_ready = 1'b1;
    step("sw M done", ctl(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));

    // BEQ x0,x0,-8 taken: compare cycle then target cycle with pc_we/pc_src=1
    set_instr(32'hFE000CE3);
    alu_zero = 1'b1;
    step("beq F", v_fetch);
    step("beq D", '0);
    step("beq E cmp", ctl(0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0));
    step("beq E tgt", ctl(0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 0, 0));

    // BEQ not taken: straight back to FETCH, no target cycle
    step("beq nt F", v_fetch);
    step("beq nt D", '0);
    alu_zero = 1'b0;
    step("beq nt E", ctl(0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0));
    mem_ready = 1'b0;
    step("beq nt back F", v_fstall);
    mem_ready = 1'b1;

    // JAL x1,16: 3 cycles, PC and rd written in EXECUTE
    set_instr(32'h010000EF);
    step("jal F", v_fetch);
    step("jal D", '0);
    step("jal E", ctl(0, 0, 0, 0, 1, 1, 4, 1, 1, 0, 1, 2, 0));

    // LW x1,0(x2): 5 cycles, writeback from memory data
    set_instr(32'h00012083);
    step("lw F", v_fetch);
    step("lw D", '0);
    step("lw E", ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step("lw M", ctl(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step("lw W", ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

    // LW interrupted by reset while in MEMORY
    step("lw2 F", v_fetch);
    step("lw2 D", '0);
    step("lw2 E", ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    mem_ready = 1'b0;
    step("lw2 M", ctl(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rst async drop", obs(), '0);
    step("rst held", '0);
    rst = 1'b0;
    mem_ready = 1'b1;
    step("post-rst F", v_fetch);
    step("post-rst D", '0);

    // Fresh start; ready on the 16th wait cycle must beat the timeout
    rst = 1'b1;
    step("rst again", '0);
    rst = 1'b0;
    set_instr(32'h00500093);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("fetch wait", v_fstall);
    mem_ready = 1'b1;
    step("limit ready wins", v_fetch);
    step("limit D", '0);
    step("limit E", ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    step("limit W", ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // 16 stalled fetch cycles then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("tmo wait", v_fstall);
    step("tmo trap", v_trap);
    mem_ready = 1'b1;
    step("trap sticky", v_trap);
    rst = 1'b1;
    step("rst clears trap", '0);
    rst = 1'b0;

    // Unknown opcode 0x7F traps out of DECODE
    set_instr(32'h0000007F);
    step("ill F", v_fetch);
    step("ill D", '0);
    step("ill trap", v_trap);
    step("ill sticky", v_trap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
